// File: rtl/rv64_pkg.sv
// Shared RV64 definitions: data width, register address width, LSU access sizes
// and the write-back record carried through the ex-result FIFO.
package rv64_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the ex, LSU, id and regfile-port signals around the write-back stage.
// The stage itself uses the slave view; whoever drives it uses the master view.
interface wb_stage_if;
    import rv64_pkg::*;

    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [REG_AW-1:0] ex_rd_i;
    logic [XLEN-1:0]   ex_data_i;

    logic              lsu_valid_i;
    logic [REG_AW-1:0] lsu_rd_i;
    logic [XLEN-1:0]   lsu_rdata_i;
    logic [1:0]        lsu_size_i;
    logic              lsu_uns_i;
    logic [2:0]        lsu_off_i;

    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_stall_o;

    logic [REG_AW-1:0] reg_waddr_o;
    logic [XLEN-1:0]   reg_wdata_o;
    logic              reg_wen_o;

    modport slave (
        input  ex_valid_i, ex_rd_i, ex_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_rdata_i, lsu_size_i, lsu_uns_i, lsu_off_i,
        input  id_rs1_i, id_rs2_i,
        output ex_ready_o, id_stall_o,
        output reg_waddr_o, reg_wdata_o, reg_wen_o
    );

    modport master (
        output ex_valid_i, ex_rd_i, ex_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_rdata_i, lsu_size_i, lsu_uns_i, lsu_off_i,
        output id_rs1_i, id_rs2_i,
        input  ex_ready_o, id_stall_o,
        input  reg_waddr_o, reg_wdata_o, reg_wen_o
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO for ex results that lost write-port arbitration. Slots are also
// presented oldest-first (slot 0 = head) so the stage can run its hazard compare.
module wb_fifo
    import rv64_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              slot_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  slot_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    wb_entry_t     mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; only count decides which slots hold live data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        slot_valid = '0;
        slot_rd    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid[k] = (CW'(k) < count);
            slot_rd[k]    = mem[rd_ptr + PW'(k)].rd;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates loads, queued ex results and bypassed ex results onto
// the single regfile write port, formats load data, and flags pending rd to id.
module wb_stage
    import rv64_pkg::wb_entry_t, rv64_pkg::lsu_size_e, rv64_pkg::REG_AW;
#(
    parameter int XLEN  = 64,   // only 64 is supported
    parameter int DEPTH = 2
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);

    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] raw,
        input lsu_size_e       size,
        input logic            uns,
        input logic [2:0]      off
    );
        logic [2:0]      eff;
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        eff = off;
        case (size)
            rv64_pkg::SZ_H: eff[0]   = 1'b0;
            rv64_pkg::SZ_W: eff[1:0] = 2'b00;
            rv64_pkg::SZ_D: eff      = 3'b000;
            default:        ;
        endcase
        lane = raw >> {eff, 3'b000};
        case (size)
            rv64_pkg::SZ_B: res = {{56{~uns & lane[7]}},  lane[7:0]};
            rv64_pkg::SZ_H: res = {{48{~uns & lane[15]}}, lane[15:0]};
            rv64_pkg::SZ_W: res = {{32{~uns & lane[31]}}, lane[31:0]};
            default:        res = lane;
        endcase
        return res;
    endfunction

    wb_entry_t                    fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0][REG_AW-1:0] slot_rd;

    logic      lsu_take;
    logic      ex_keep;
    logic      fifo_pop;
    logic      fifo_push;
    logic      bypass;
    logic      sel_any;
    wb_entry_t sel_entry;
    logic      stall;

    logic              wen_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;

    // rd==0 results are consumed here but never claim the write port or a FIFO slot.
    always_comb begin
        lsu_take  = bus.lsu_valid_i && (bus.lsu_rd_i != '0);
        ex_keep   = bus.ex_valid_i && !fifo_full && !rst && (bus.ex_rd_i != '0);
        fifo_pop  = !fifo_empty && !lsu_take;
        bypass    = ex_keep && fifo_empty && !lsu_take;
        fifo_push = ex_keep && !bypass;
        sel_any   = lsu_take || fifo_pop || bypass;
        sel_entry = '0;
        if (lsu_take) begin
            sel_entry.rd   = bus.lsu_rd_i;
            sel_entry.data = format_load(bus.lsu_rdata_i, lsu_size_e'(bus.lsu_size_i),
                                         bus.lsu_uns_i, bus.lsu_off_i);
        end else if (fifo_pop) begin
            sel_entry = fifo_head;
        end else if (bypass) begin
            sel_entry.rd   = bus.ex_rd_i;
            sel_entry.data = bus.ex_data_i;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry ({bus.ex_rd_i, bus.ex_data_i}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    // The head leaving this cycle is already on its way to the regfile bypass.
    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k] && !(k == 0 && fifo_pop)) begin
                if ((bus.id_rs1_i != '0 && slot_rd[k] == bus.id_rs1_i) ||
                    (bus.id_rs2_i != '0 && slot_rd[k] == bus.id_rs2_i))
                    stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= sel_any;
            if (sel_any) begin
                waddr_q <= sel_entry.rd;
                wdata_q <= sel_entry.data;
            end
        end
    end

    assign bus.ex_ready_o  = !fifo_full;
    assign bus.id_stall_o  = stall && !rst;
    assign bus.reg_wen_o   = wen_q;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_wb_stage;
    import rv64_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

    logic clk = 1'b0;
    logic rst;

    wb_stage_if bus();

    wb_stage #(.XLEN(64), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    wb_entry_t   q[$];
    logic        exp_wen = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [63:0] exp_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatter written directly from the byte-lane rules.
    function automatic logic [63:0] ref_load(input logic [63:0] raw, input int size,
                                             input logic uns, input int off);
        int          nbytes;
        int          o;
        logic [63:0] mask;
        logic [63:0] v;
        nbytes = 1 << size;
        o      = (off / nbytes) * nbytes;
        mask   = (nbytes == 8) ? '1 : ((64'd1 << (nbytes * 8)) - 64'd1);
        v      = (raw >> (o * 8)) & mask;
        if (!uns && nbytes < 8 && v[nbytes*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle();
        bus.ex_valid_i  = 1'b0;
        bus.ex_rd_i     = '0;
        bus.ex_data_i   = '0;
        bus.lsu_valid_i = 1'b0;
        bus.lsu_rd_i    = '0;
        bus.lsu_rdata_i = '0;
        bus.lsu_size_i  = '0;
        bus.lsu_uns_i   = 1'b0;
        bus.lsu_off_i   = '0;
        bus.id_rs1_i    = '0;
        bus.id_rs2_i    = '0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [63:0] data,
                              input int size, input logic uns, input int off);
        bus.lsu_valid_i = 1'b1;
        bus.lsu_rd_i    = rd;
        bus.lsu_rdata_i = data;
        bus.lsu_size_i  = 2'(size);
        bus.lsu_uns_i   = uns;
        bus.lsu_off_i   = 3'(off);
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic [63:0] data);
        bus.ex_valid_i = 1'b1;
        bus.ex_rd_i    = rd;
        bus.ex_data_i  = data;
    endtask

    // Called just after a negedge with inputs driven; compares the combinational
    // outputs, advances the model across the posedge and compares the write port.
    task automatic step();
        logic ready;
        logic load_w;
        logic pop;
        logic stall;
        logic wrote_ex;
        #1;
        ready  = (q.size() < DEPTH);
        load_w = bus.lsu_valid_i && bus.lsu_rd_i != 0;
        pop    = !rst && !load_w && q.size() > 0;
        stall  = 1'b0;
        if (!rst) begin
            for (int i = (pop ? 1 : 0); i < q.size(); i++) begin
                if ((bus.id_rs1_i != 0 && q[i].rd == bus.id_rs1_i) ||
                    (bus.id_rs2_i != 0 && q[i].rd == bus.id_rs2_i))
                    stall = 1'b1;
            end
        end
        check("ex_ready", bus.ex_ready_o, ready);
        check("id_stall", bus.id_stall_o, stall);

        wrote_ex = 1'b0;
        if (rst) begin
            q.delete();
            exp_wen = 1'b0;
        end else begin
            exp_wen = 1'b1;
            if (load_w) begin
                exp_waddr = bus.lsu_rd_i;
                exp_wdata = ref_load(bus.lsu_rdata_i, int'(bus.lsu_size_i), bus.lsu_uns_i,
                                     int'(bus.lsu_off_i));
            end else if (q.size() > 0) begin
                exp_waddr = q[0].rd;
                exp_wdata = q[0].data;
                void'(q.pop_front());
            end else if (bus.ex_valid_i && ready && bus.ex_rd_i != 0) begin
                exp_waddr = bus.ex_rd_i;
                exp_wdata = bus.ex_data_i;
                wrote_ex  = 1'b1;
            end else begin
                exp_wen = 1'b0;
            end
            if (bus.ex_valid_i && ready && bus.ex_rd_i != 0 && !wrote_ex)
                q.push_back('{rd: bus.ex_rd_i, data: bus.ex_data_i});
        end

        @(posedge clk);
        #1;
        check("reg_wen", bus.reg_wen_o, exp_wen);
        if (exp_wen) begin
            check("reg_waddr", bus.reg_waddr_o, exp_waddr);
            check("reg_wdata", bus.reg_wdata_o, exp_wdata);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wen",   bus.reg_wen_o,   0);
        check("rst_waddr", bus.reg_waddr_o, 0);
        check("rst_wdata", bus.reg_wdata_o, 0);
        check("rst_ready", bus.ex_ready_o,  1);
        check("rst_stall", bus.id_stall_o,  0);

        // Model pins for the load formatter.
        check("pin_b7s", ref_load(RAW, 0, 1'b0, 7), 64'hFFFF_FFFF_FFFF_FF88);
        check("pin_h2u", ref_load(RAW, 1, 1'b1, 2), 64'h0000_0000_0000_4433);
        check("pin_w5s", ref_load(RAW, 2, 1'b0, 5), 64'hFFFF_FFFF_8877_6655);
        check("pin_d",   ref_load(RAW, 3, 1'b0, 5), RAW);

        // Load lane select and extension.
        idle(); drive_load(5'd1, RAW, 0, 1'b0, 7); step();
        check("t1_b7s", bus.reg_wdata_o, 64'hFFFF_FFFF_FFFF_FF88);
        idle(); drive_load(5'd1, RAW, 1, 1'b1, 2); step();
        check("t1_h2u", bus.reg_wdata_o, 64'h0000_0000_0000_4433);
        idle(); drive_load(5'd1, RAW, 2, 1'b0, 5); step();
        check("t1_w5s", bus.reg_wdata_o, 64'hFFFF_FFFF_8877_6655);
        idle(); drive_load(5'd2, RAW, 3, 1'b1, 3); step();
        check("t1_d", bus.reg_wdata_o, RAW);

        // Lone ex result, single-cycle write.
        idle(); drive_ex(5'd3, 64'h55); step();
        check("t2_wen",   bus.reg_wen_o,   1);
        check("t2_waddr", bus.reg_waddr_o, 3);
        check("t2_wdata", bus.reg_wdata_o, 64'h55);
        idle(); step();
        check("t2_wen_off", bus.reg_wen_o, 0);

        // Load and ex together: load first, ex next.
        idle(); drive_load(5'd4, RAW, 3, 1'b0, 0); drive_ex(5'd5, 64'hABCD); step();
        check("t3_load_addr", bus.reg_waddr_o, 4);
        idle(); bus.id_rs1_i = 5'd5; step();
        check("t3_ex_addr", bus.reg_waddr_o, 5);
        check("t3_ex_data", bus.reg_wdata_o, 64'hABCD);
        // Same, but a second load keeps the ex result queued so id must stall.
        idle(); drive_load(5'd4, RAW, 3, 1'b0, 0); drive_ex(5'd5, 64'h1234); step();
        idle(); drive_load(5'd6, RAW, 0, 1'b1, 0); bus.id_rs1_i = 5'd5;
        #1 check("t3_stall", bus.id_stall_o, 1);
        step();
        idle(); bus.id_rs2_i = 5'd5; step();
        check("t3_ex_late", bus.reg_waddr_o, 5);

        // Back-to-back loads with ex pressure fill the FIFO.
        for (int c = 0; c < 4; c++) begin
            idle();
            drive_load(5'(10 + c), RAW, c % 4, 1'b0, c);
            drive_ex(5'(20 + c), 64'(c + 100));
            if (c >= 2) #1 check("t4_ready_low", bus.ex_ready_o, 0);
            step();
        end
        idle(); step();
        check("t4_first", bus.reg_waddr_o, 20);
        idle(); step();
        check("t4_second", bus.reg_waddr_o, 21);
        idle(); step();

        // rd==0 from both sources.
        idle(); drive_load(5'd0, RAW, 3, 1'b0, 0); drive_ex(5'd0, 64'h77); step();
        check("t5_wen", bus.reg_wen_o, 0);
        idle(); drive_ex(5'd0, 64'h78); step();
        check("t5_wen2", bus.reg_wen_o, 0);
        check("t5_ready", bus.ex_ready_o, 1);

        // Reset with two queued entries.
        idle(); drive_load(5'd1, RAW, 3, 1'b0, 0); drive_ex(5'd7, 64'h7); step();
        idle(); drive_load(5'd2, RAW, 3, 1'b0, 0); drive_ex(5'd8, 64'h8); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0; bus.id_rs1_i = 5'd7; bus.id_rs2_i = 5'd8;
        #1;
        check("t6_wen",   bus.reg_wen_o,  0);
        check("t6_stall", bus.id_stall_o, 0);
        check("t6_ready", bus.ex_ready_o, 1);
        step();
        check("t6_no_write", bus.reg_wen_o, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bus.ex_valid_i  = ($urandom_range(0, 99) < 55);
            bus.ex_rd_i     = 5'($urandom_range(0, 7));
            bus.ex_data_i   = {$urandom, $urandom};
            bus.lsu_valid_i = ($urandom_range(0, 99) < 35);
            bus.lsu_rd_i    = 5'($urandom_range(0, 7));
            bus.lsu_rdata_i = {$urandom, $urandom};
            bus.lsu_size_i  = 2'($urandom_range(0, 3));
            bus.lsu_uns_i   = 1'($urandom_range(0, 1));
            bus.lsu_off_i   = 3'($urandom_range(0, 7));
            bus.id_rs1_i    = 5'($urandom_range(0, 7));
            bus.id_rs2_i    = 5'($urandom_range(0, 7));
            rst             = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
